mod_updown_counter: RTL and testbench
=====================================

# mod_updown_counter

Parameterised up/down counter: programmable terminal value, wrap or saturate mode, synchronous load and clear, and an enable prescaler. It generalises the fixed 4-bit free-running counter into a reusable block for timers, display multiplexers and event counters. It sits directly on the system clock and drives count and terminal flags to downstream logic.

## Interface
- WIDTH, 4, counter width in bits (≥1)
- MAX, 2**WIDTH-1, terminal value; count range 0..MAX (1 ≤ MAX ≤ 2**WIDTH-1)
- PRESCALE, 1, enabled clock cycles per count step (≥1)

- clk  input  1  system clock, rising-edge
- rst  input  1  reset, asynchronous, active-low
- en  input  1  count enable; advances prescaler
- up  input  1  direction: 1 = up, 0 = down
- sat  input  1  mode: 1 = saturate at limit, 0 = wrap
- clr  input  1  synchronous clear
- load  input  1  synchronous load
- load_val  input  WIDTH  load value
- out  output  WIDTH  registered count
- wrap  output  1  registered one-cycle wrap pulse
- at_limit  output  1  combinational: (up && out==MAX) || (!up && out==0)

## Operation
- Internal prescaler pre_cnt, width max(1, $clog2(PRESCALE)), range 0..PRESCALE-1.
- Per-edge priority: rst > clr > load > step.
- rst low: out=0, pre_cnt=0, wrap=0, immediately, no clock edge needed.
- clr: out←0, pre_cnt←0, wrap←0.
- load: out←min(load_val, MAX), pre_cnt←0, wrap←0; en ignored that cycle.
- step condition: en && pre_cnt==PRESCALE-1; pre_cnt←0 on step, pre_cnt+1 on en without step, hold when en low.
- PRESCALE=1: every enabled cycle is a step.
- Step, up: out<MAX → out+1; out==MAX → wrap mode: out←0, wrap←1; saturate mode: hold, wrap←0.
- Step, down: out>0 → out-1; out==0 → wrap mode: out←MAX, wrap←1; saturate mode: hold, wrap←0.
- wrap←0 on every edge without a wrap event (single-cycle pulse even if wrapping repeatedly, e.g. MAX=1 toggles are separate pulses each step).
- Changing up or sat mid-prescale does not reset pre_cnt; new values take effect at next step.
- out never exceeds MAX under any input sequence; arithmetic is modulo MAX+1, not 2**WIDTH.

## Timing
- Reset values: out=0, wrap=0, at_limit=0 after reset only if up=1 and MAX≠0 (follows combinational rule; with up=0, at_limit=1).
- Step, load, clr: 1-cycle latency; out valid after the rising edge that samples the request.
- wrap asserts on the same edge that out takes its wrapped value; high exactly one cycle.
- at_limit has zero latency from out/up; no register.
- First step after enable with PRESCALE=N occurs on the Nth consecutive enabled edge; en gaps pause, not restart, the prescaler.
- rst deassertion is sampled on the next rising edge; counting resumes from 0 with pre_cnt=0.

## Test plan
- Async reset: WIDTH=4, MAX=9, count to 5, drop rst between edges -> out=0, wrap=0 before next edge; hold rst low 2 edges, out stays 0.
- Up wrap: MAX=9, PRESCALE=1, up=1, sat=0, en high 12 cycles from 0 -> out 1..9,0,1,2; wrap high exactly the one cycle out=0.
- Down saturate: load_val=2, then up=0, sat=1, en 5 cycles -> out 1,0,0,0,0; wrap never high; at_limit high once out=0.
- Down wrap: out=0, up=0, sat=0, one step -> out=9, wrap=1 one cycle, at_limit=0.
- Prescaler: PRESCALE=3, en high 4 cycles, low 2, high 5 -> out steps after enabled cycles 3, 6, 9 -> final out=3; out stable while en low.
- Priority/clamp: clr=1 and load=1 same edge -> out=0; load_val=15 with MAX=9 -> out=9; load mid-prescale -> next step needs full 3 enabled cycles.

Source files
------------

// File: rtl/mod_updown_counter.sv
// Parameterised up/down counter with programmable terminal value, wrap/saturate
// mode, synchronous clear/load and an enable prescaler.
module mod_updown_counter #(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned MAX      = 2**WIDTH - 1,
    parameter int unsigned PRESCALE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             sat,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] out,
    output logic             wrap,
    output logic             at_limit
);

    localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [WIDTH-1:0] MAX_V  = WIDTH'(MAX);
    localparam logic [PW-1:0]    PRE_LAST = PW'(PRESCALE - 1);

    logic [PW-1:0]    pre_cnt;
    logic [PW-1:0]    pre_cnt_nxt;
    logic [WIDTH-1:0] out_nxt;
    logic             wrap_nxt;

    // Next-state: clear beats load beats a prescaled step.
    always_comb begin
        out_nxt     = out;
        pre_cnt_nxt = pre_cnt;
        wrap_nxt    = 1'b0;
        if (clr) begin
            out_nxt     = '0;
            pre_cnt_nxt = '0;
        end else if (load) begin
            out_nxt     = (load_val > MAX_V) ? MAX_V : load_val;
            pre_cnt_nxt = '0;
        end else if (en) begin
            if (pre_cnt == PRE_LAST) begin
                pre_cnt_nxt = '0;
                if (up) begin
                    if (out < MAX_V) begin
                        out_nxt = out + WIDTH'(1);
                    end else if (!sat) begin
                        out_nxt  = '0;
                        wrap_nxt = 1'b1;
                    end
                end else begin
                    if (out != '0) begin
                        out_nxt = out - WIDTH'(1);
                    end else if (!sat) begin
                        out_nxt  = MAX_V;
                        wrap_nxt = 1'b1;
                    end
                end
            end else begin
                pre_cnt_nxt = pre_cnt + PW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out     <= '0;
            pre_cnt <= '0;
            wrap    <= 1'b0;
        end else begin
            out     <= out_nxt;
            pre_cnt <= pre_cnt_nxt;
            wrap    <= wrap_nxt;
        end
    end

    // Terminal flag follows direction with no register delay.
    assign at_limit = up ? (out == MAX_V) : (out == '0);

endmodule

// File: tb/tb_mod_updown_counter.sv
// Self-checking bench: two counters (PRESCALE 1 and 3, MAX 9) sharing stimulus,
// with a scoreboard of expected outputs plus directed constant checks.
module tb_mod_updown_counter;

    localparam int unsigned W  = 4;
    localparam int unsigned MX = 9;

    logic         clk = 1'b0;
    logic         rst;
    logic         en, up, sat, clr, load;
    logic [W-1:0] load_val;
    logic [W-1:0] out1, out3;
    logic         wrap1, wrap3, lim1, lim3;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [W-1:0] o;
        logic         w;
    } exp_t;

    exp_t q1[$];
    exp_t q3[$];

    int m_out[2];
    int m_pre[2];
    bit m_wrap[2];
    int pres[2] = '{1, 3};

    always #5 clk = ~clk;

    mod_updown_counter #(.WIDTH(W), .MAX(MX), .PRESCALE(1)) dut1 (
        .clk(clk), .rst(rst), .en(en), .up(up), .sat(sat), .clr(clr),
        .load(load), .load_val(load_val), .out(out1), .wrap(wrap1), .at_limit(lim1)
    );

    mod_updown_counter #(.WIDTH(W), .MAX(MX), .PRESCALE(3)) dut3 (
        .clk(clk), .rst(rst), .en(en), .up(up), .sat(sat), .clr(clr),
        .load(load), .load_val(load_val), .out(out3), .wrap(wrap3), .at_limit(lim3)
    );

    // Reference behaviour for one counter, applied to the inputs about to be sampled.
    task automatic model_step(input int i);
        if (clr) begin
            m_out[i] = 0; m_pre[i] = 0; m_wrap[i] = 0;
        end else if (load) begin
            m_out[i] = (int'(load_val) > int'(MX)) ? int'(MX) : int'(load_val);
            m_pre[i] = 0; m_wrap[i] = 0;
        end else if (en && m_pre[i] == pres[i] - 1) begin
            m_pre[i]  = 0;
            m_wrap[i] = 0;
            if (up) begin
                if (m_out[i] < int'(MX)) m_out[i]++;
                else if (!sat) begin m_out[i] = 0; m_wrap[i] = 1; end
            end else begin
                if (m_out[i] > 0) m_out[i]--;
                else if (!sat) begin m_out[i] = int'(MX); m_wrap[i] = 1; end
            end
        end else begin
            if (en) m_pre[i]++;
            m_wrap[i] = 0;
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_out[i] = 0; m_pre[i] = 0; m_wrap[i] = 0;
        end
        q1.delete();
        q3.delete();
    endtask

    // Push expectations for the coming edge, then advance one clock.
    task automatic cycle();
        exp_t e;
        for (int i = 0; i < 2; i++) begin
            model_step(i);
            e.o = W'(m_out[i]);
            e.w = m_wrap[i];
            if (i == 0) q1.push_back(e);
            else        q3.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: pops one expectation per DUT per edge.
    initial begin
        exp_t e;
        logic el;
        forever begin
            @(posedge clk);
            #1;
            if (q1.size() > 0) begin
                e  = q1.pop_front();
                el = up ? (e.o == W'(MX)) : (e.o == '0);
                checks += 3;
                if (out1 !== e.o) begin
                    errors++;
                    $display("FAIL sb_out1 t=%0t got %0d exp %0d", $time, out1, e.o);
                end
                if (wrap1 !== e.w) begin
                    errors++;
                    $display("FAIL sb_wrap1 t=%0t got %0b exp %0b", $time, wrap1, e.w);
                end
                if (lim1 !== el) begin
                    errors++;
                    $display("FAIL sb_lim1 t=%0t got %0b exp %0b", $time, lim1, el);
                end
            end
            if (q3.size() > 0) begin
                e  = q3.pop_front();
                el = up ? (e.o == W'(MX)) : (e.o == '0);
                checks += 3;
                if (out3 !== e.o) begin
                    errors++;
                    $display("FAIL sb_out3 t=%0t got %0d exp %0d", $time, out3, e.o);
                end
                if (wrap3 !== e.w) begin
                    errors++;
                    $display("FAIL sb_wrap3 t=%0t got %0b exp %0b", $time, wrap3, e.w);
                end
                if (lim3 !== el) begin
                    errors++;
                    $display("FAIL sb_lim3 t=%0t got %0b exp %0b", $time, lim3, el);
                end
            end
        end
    end

    task automatic test_reset();
        rst = 1'b0; en = 1'b0; up = 1'b1; sat = 1'b0; clr = 1'b0; load = 1'b0;
        load_val = '0;
        model_reset();
        #12;
        checks += 3;
        if (out1 !== 4'd0 || out3 !== 4'd0) begin
            errors++; $display("FAIL reset_out got %0d/%0d exp 0", out1, out3);
        end
        if (wrap1 !== 1'b0) begin
            errors++; $display("FAIL reset_wrap got %0b exp 0", wrap1);
        end
        if (lim1 !== 1'b0) begin
            errors++; $display("FAIL reset_lim_up got %0b exp 0", lim1);
        end
        up = 1'b0;
        #1;
        checks++;
        if (lim1 !== 1'b1) begin
            errors++; $display("FAIL reset_lim_down got %0b exp 1", lim1);
        end
        up = 1'b1;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_async_reset();
        en = 1'b1; up = 1'b1; sat = 1'b0;
        for (int i = 0; i < 5; i++) cycle();
        checks++;
        if (out1 !== 4'd5) begin
            errors++; $display("FAIL async_pre got %0d exp 5", out1);
        end
        #3;
        rst = 1'b0;
        model_reset();
        #1;
        checks += 2;
        if (out1 !== 4'd0 || out3 !== 4'd0) begin
            errors++; $display("FAIL async_out got %0d/%0d exp 0", out1, out3);
        end
        if (wrap1 !== 1'b0) begin
            errors++; $display("FAIL async_wrap got %0b exp 0", wrap1);
        end
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (out1 !== 4'd0) begin
                errors++; $display("FAIL async_hold edge %0d got %0d exp 0", i, out1);
            end
        end
        @(negedge clk);
        rst = 1'b1;
        en  = 1'b0;
    endtask

    task automatic test_up_wrap();
        logic [W-1:0] seq [12] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8,
                                   4'd9, 4'd0, 4'd1, 4'd2};
        en = 1'b1; up = 1'b1; sat = 1'b0;
        for (int i = 0; i < 12; i++) begin
            cycle();
            checks += 2;
            if (out1 !== seq[i]) begin
                errors++; $display("FAIL up_wrap_out step %0d got %0d exp %0d", i, out1, seq[i]);
            end
            if (wrap1 !== (i == 9)) begin
                errors++; $display("FAIL up_wrap_pulse step %0d got %0b exp %0b", i, wrap1, (i == 9));
            end
        end
        en = 1'b0;
    endtask

    task automatic test_down_sat();
        logic [W-1:0] seq [5] = '{4'd1, 4'd0, 4'd0, 4'd0, 4'd0};
        load = 1'b1; load_val = 4'd2; en = 1'b0;
        cycle();
        load = 1'b0; up = 1'b0; sat = 1'b1; en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cycle();
            checks += 3;
            if (out1 !== seq[i]) begin
                errors++; $display("FAIL down_sat_out step %0d got %0d exp %0d", i, out1, seq[i]);
            end
            if (wrap1 !== 1'b0) begin
                errors++; $display("FAIL down_sat_wrap step %0d got %0b exp 0", i, wrap1);
            end
            if (lim1 !== (i >= 1)) begin
                errors++; $display("FAIL down_sat_lim step %0d got %0b exp %0b", i, lim1, (i >= 1));
            end
        end
        en = 1'b0;
    endtask

    task automatic test_down_wrap();
        up = 1'b0; sat = 1'b0; en = 1'b1;
        cycle();
        checks += 3;
        if (out1 !== 4'd9) begin
            errors++; $display("FAIL down_wrap_out got %0d exp 9", out1);
        end
        if (wrap1 !== 1'b1) begin
            errors++; $display("FAIL down_wrap_pulse got %0b exp 1", wrap1);
        end
        if (lim1 !== 1'b0) begin
            errors++; $display("FAIL down_wrap_lim got %0b exp 0", lim1);
        end
        en = 1'b0;
        cycle();
        checks++;
        if (wrap1 !== 1'b0) begin
            errors++; $display("FAIL down_wrap_clear got %0b exp 0", wrap1);
        end
    endtask

    task automatic test_prescaler();
        logic [W-1:0] seq [11] = '{4'd0, 4'd0, 4'd1, 4'd1, 4'd1, 4'd1, 4'd1,
                                   4'd2, 4'd2, 4'd2, 4'd3};
        logic         ens [11] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1,
                                   1'b1, 1'b1, 1'b1, 1'b1};
        clr = 1'b1;
        cycle();
        clr = 1'b0; up = 1'b1; sat = 1'b0;
        for (int i = 0; i < 11; i++) begin
            en = ens[i];
            cycle();
            checks++;
            if (out3 !== seq[i]) begin
                errors++; $display("FAIL prescale_out cyc %0d got %0d exp %0d", i, out3, seq[i]);
            end
        end
        en = 1'b0;
    endtask

    task automatic test_priority();
        clr = 1'b1; load = 1'b1; load_val = 4'd5;
        cycle();
        checks++;
        if (out1 !== 4'd0 || out3 !== 4'd0) begin
            errors++; $display("FAIL clr_over_load got %0d/%0d exp 0", out1, out3);
        end
        clr = 1'b0; load_val = 4'd15;
        cycle();
        checks++;
        if (out1 !== 4'd9 || out3 !== 4'd9) begin
            errors++; $display("FAIL load_clamp got %0d/%0d exp 9", out1, out3);
        end
        load = 1'b0; clr = 1'b1;
        cycle();
        clr = 1'b0; up = 1'b1; en = 1'b1;
        cycle();
        cycle();
        load = 1'b1; load_val = 4'd4;
        cycle();
        checks++;
        if (out3 !== 4'd4) begin
            errors++; $display("FAIL load_mid got %0d exp 4", out3);
        end
        load = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            checks++;
            if (out3 !== ((i == 2) ? 4'd5 : 4'd4)) begin
                errors++; $display("FAIL load_restart cyc %0d got %0d exp %0d", i, out3,
                                   (i == 2) ? 5 : 4);
            end
        end
        en = 1'b0;
    endtask

    task automatic test_up_sat();
        load = 1'b1; load_val = 4'd8;
        cycle();
        load = 1'b0; up = 1'b1; sat = 1'b1; en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            checks += 2;
            if (out1 !== 4'd9) begin
                errors++; $display("FAIL up_sat_out cyc %0d got %0d exp 9", i, out1);
            end
            if (wrap1 !== 1'b0) begin
                errors++; $display("FAIL up_sat_wrap cyc %0d got %0b exp 0", i, wrap1);
            end
        end
        en = 1'b0;
        cycle();
    endtask

    initial begin
        test_reset();
        test_async_reset();
        test_up_wrap();
        test_down_sat();
        test_down_wrap();
        test_prescaler();
        test_priority();
        test_up_sat();
        #20;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
